// File: rtl/deconvolution_pkg.sv
// Shared types and constants for the deconvolution block: FSM states,
// residual width and output saturation limits.
package deconvolution_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DIV, OUT} state_t;

  localparam int DEF_N = 16;

  // Residual carries y (2N) minus up to LEN1-1 products (2N each) plus sign headroom.
  function automatic int res_width(input int n);
    return 2 * n + 2;
  endfunction

  function automatic longint sat_max(input int n);
    return (longint'(1) <<< (n - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int n);
    return -(longint'(1) <<< (n - 1));
  endfunction

endpackage

// File: rtl/deconvolution_if.sv
// Streaming handshake bundle: convolved samples in, recovered samples out.
interface deconvolution_if #(parameter int N = 16);

  logic                  in_valid;
  logic                  in_ready;
  logic signed [2*N-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [N-1:0]   out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);

endinterface

// File: rtl/deconv_div.sv
// Restoring serial divider: signed RW-bit dividend by signed N-bit divisor,
// one quotient bit per cycle, result rounded toward zero.
module deconv_div
  import deconvolution_pkg::*;
#(
  parameter int N  = 16,
  parameter int RW = res_width(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [RW-1:0] dividend,
  input  logic signed [N-1:0]  divisor,
  output logic signed [RW-1:0] quotient,
  output logic                 done
);

  localparam int CW = $clog2(RW + 1);

  logic [N-1:0]  rem;
  logic [N-1:0]  dvs_abs;
  logic [RW-1:0] quo;
  logic [CW-1:0] cnt;
  logic          neg;
  logic          busy;

  logic [RW-1:0] dvd_abs;
  logic [N-1:0]  dvs_in_abs;
  logic [N-1:0]  rem_in;
  logic [N-1:0]  dvs_use;
  logic [N:0]    trial;
  logic          bit_in;
  logic          q_bit;
  logic [N-1:0]  rem_nxt;

  assign dvd_abs    = dividend[RW-1] ? $unsigned(-dividend) : $unsigned(dividend);
  assign dvs_in_abs = divisor[N-1]   ? $unsigned(-divisor)  : $unsigned(divisor);

  // The load cycle already performs the first shift/subtract, so the
  // quotient is complete RW cycles after start, counting the start edge.
  always_comb begin
    rem_in  = start ? '0 : rem;
    bit_in  = start ? dvd_abs[RW-1] : quo[RW-1];
    dvs_use = start ? dvs_in_abs : dvs_abs;
    trial   = {rem_in, bit_in};
    q_bit   = (trial >= {1'b0, dvs_use});
    rem_nxt = q_bit ? N'(trial - {1'b0, dvs_use}) : N'(trial);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      dvs_abs <= '0;
      quo     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
    end else if (start) begin
      rem     <= rem_nxt;
      quo     <= {dvd_abs[RW-2:0], q_bit};
      dvs_abs <= dvs_in_abs;
      neg     <= dividend[RW-1] ^ divisor[N-1];
      cnt     <= CW'(RW - 1);
      busy    <= 1'b1;
    end else if (busy && cnt != '0) begin
      rem <= rem_nxt;
      quo <= {quo[RW-2:0], q_bit};
      cnt <= cnt - 1'b1;
    end
  end

  assign quotient = neg ? -$signed(quo) : $signed(quo);
  assign done     = busy && (cnt == '0);

endmodule

// File: rtl/deconvolution.sv
// Sample-by-sample inverse FIR: x[n] = (y[n] - sum h[k]*x[n-k]) / h[0].
// Define DECONV_SAT_EN to saturate out-of-range quotients instead of wrapping.
//
// state | meaning
// IDLE  | waiting for a sample, in_ready high once out of reset
// MAC   | one tap product subtracted from the residual per cycle
// DIV   | serial division of the residual by h[0]
// OUT   | result held on out_data until out_ready
module deconvolution
  import deconvolution_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int LEN1 = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LEN1*N-1:0] signal1,
  input  logic              start,
  deconvolution_if.slave    bus,
  output logic              div_err
);

  localparam int RW = res_width(N);
  localparam int CW = $clog2(LEN1 + 1);
  localparam logic signed [N-1:0] OUT_MAX = N'(sat_max(N));
  localparam logic signed [N-1:0] OUT_MIN = N'(sat_min(N));
`ifdef DECONV_SAT_EN
  localparam logic signed [RW-1:0] Q_MAX = RW'(sat_max(N));
  localparam logic signed [RW-1:0] Q_MIN = RW'(sat_min(N));
`endif

  state_t              state;
  logic [LEN1*N-1:0]   taps_q;
  logic signed [N-1:0] hist [LEN1-1];
  logic signed [RW-1:0] acc;
  logic [CW-1:0]       mac_cnt;

  logic signed [N-1:0]   tap_sel;
  logic signed [N-1:0]   hist_sel;
  logic signed [2*N-1:0] prod;
  logic signed [RW-1:0]  acc_nxt;
  logic signed [RW-1:0]  quo;
  logic signed [N-1:0]   result;
  logic                  div_start;
  logic                  div_done;
  logic                  accept;
  logic                  h0_zero;

  assign accept    = (state == IDLE) && bus.in_ready && bus.in_valid;
  assign div_start = (state == MAC) && (mac_cnt == CW'(1));
  assign h0_zero   = ~|taps_q[N-1:0];

  // mac_cnt counts down from LEN1-1, selecting taps 1..LEN1-1 in turn.
  always_comb begin
    tap_sel  = '0;
    hist_sel = '0;
    for (int k = 1; k < LEN1; k++) begin
      if (mac_cnt == CW'(LEN1 - k)) begin
        tap_sel  = taps_q[k*N +: N];
        hist_sel = hist[k-1];
      end
    end
    prod    = tap_sel * hist_sel;
    acc_nxt = acc - {{(RW-2*N){prod[2*N-1]}}, prod};
  end

  always_comb begin
    result = '0;
    if (h0_zero) begin
      if (acc[RW-1])     result = OUT_MIN;
      else if (|acc)     result = OUT_MAX;
    end else begin
`ifdef DECONV_SAT_EN
      if (quo > Q_MAX)      result = OUT_MAX;
      else if (quo < Q_MIN) result = OUT_MIN;
      else                  result = N'(quo);
`else
      result = N'(quo);
`endif
    end
  end

  // Dividend is the residual including the last MAC product, so the
  // divider starts on the same edge that enters DIV.
  deconv_div #(.N(N), .RW(RW)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (acc_nxt),
    .divisor  (taps_q[N-1:0]),
    .quotient (quo),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      taps_q        <= '0;
      acc           <= '0;
      mac_cnt       <= '0;
      div_err       <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      for (int k = 0; k < LEN1 - 1; k++) hist[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_err <= 1'b0;
            for (int k = 0; k < LEN1 - 1; k++) hist[k] <= '0;
          end
          if (accept) begin
            taps_q       <= signal1;
            acc          <= {{(RW-2*N){bus.in_data[2*N-1]}}, bus.in_data};
            mac_cnt      <= CW'(LEN1 - 1);
            bus.in_ready <= 1'b0;
            state        <= MAC;
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        MAC: begin
          acc     <= acc_nxt;
          mac_cnt <= mac_cnt - 1'b1;
          if (mac_cnt == CW'(1)) state <= DIV;
        end
        DIV: begin
          if (div_done) begin
            bus.out_data  <= result;
            bus.out_valid <= 1'b1;
            if (h0_zero) div_err <= 1'b1;
            state <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            for (int k = LEN1 - 2; k > 0; k--) hist[k] <= hist[k-1];
            hist[0] <= bus.out_data;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deconvolution.sv
// Directed testbench for deconvolution with hand-computed expected samples.
module tb_deconvolution;

  localparam int N    = 16;
  localparam int LEN1 = 3;
  localparam int LAT  = 36;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LEN1*N-1:0] signal1 = '0;
  logic              div_err;

  int errors = 0;
  int checks = 0;

  deconvolution_if #(.N(N)) bus ();

  deconvolution #(.N(N), .LEN1(LEN1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .signal1 (signal1),
    .start   (start),
    .bus     (bus),
    .div_err (div_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_taps(input int t0, input int t1, input int t2);
    signal1[0*N +: N] = N'(t0);
    signal1[1*N +: N] = N'(t1);
    signal1[2*N +: N] = N'(t2);
  endtask

  // Called and returns #1 after a rising edge; out_ready must be high.
  task automatic send(input int y, input logic st, output int lat, output int data);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    bus.in_data  = 32'(y);
    bus.in_valid = 1'b1;
    start        = st;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    start        = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    data = int'(bus.out_data);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (div_err !== 1'b0) begin errors++; $display("FAIL reset_div_err: got %b expected 0", div_err); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_early: got %b expected 0", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_recover();
    int ys[3] = '{81900, -237550, 235133};
    int xs[3] = '{100, -50, 7};
    int lat, d;
    set_taps(819, -1966, 1311);
    for (int i = 0; i < 3; i++) begin
      send(ys[i], (i == 0), lat, d);
      checks++; if (d !== xs[i]) begin errors++; $display("FAIL recover_data[%0d]: got %0d expected %0d", i, d, xs[i]); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL recover_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
    end
    checks++; if (div_err !== 1'b0) begin errors++; $display("FAIL recover_div_err: got %b expected 0", div_err); end
  endtask

  task automatic test_zero_tap();
    int lat, d;
    set_taps(0, 0, 0);
    send(5, 1'b1, lat, d);
    checks++; if (d !== 32767) begin errors++; $display("FAIL zero_tap_pos: got %0d expected 32767", d); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL zero_tap_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (div_err !== 1'b1) begin errors++; $display("FAIL zero_tap_div_err: got %b expected 1", div_err); end
    send(0, 1'b0, lat, d);
    checks++; if (d !== 0) begin errors++; $display("FAIL zero_tap_zero: got %0d expected 0", d); end
    send(-3, 1'b0, lat, d);
    checks++; if (d !== -32768) begin errors++; $display("FAIL zero_tap_neg: got %0d expected -32768", d); end
    checks++; if (div_err !== 1'b1) begin errors++; $display("FAIL zero_tap_sticky: got %b expected 1", div_err); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (div_err !== 1'b0) begin errors++; $display("FAIL zero_tap_clear: got %b expected 0", div_err); end
  endtask

  task automatic test_wrap();
    int lat, d, e_pos, e_neg;
`ifdef DECONV_SAT_EN
    e_pos = 32767;  e_neg = -32768;
`else
    e_pos = -25536; e_neg = 25536;
`endif
    set_taps(1, 0, 0);
    send(40000, 1'b1, lat, d);
    checks++; if (d !== e_pos) begin errors++; $display("FAIL wrap_pos: got %0d expected %0d", d, e_pos); end
    send(-40000, 1'b0, lat, d);
    checks++; if (d !== e_neg) begin errors++; $display("FAIL wrap_neg: got %0d expected %0d", d, e_neg); end
  endtask

  task automatic test_round();
    int lat, d;
    set_taps(4, 0, 0);
    send(-7, 1'b1, lat, d);
    checks++; if (d !== -1) begin errors++; $display("FAIL round_neg: got %0d expected -1", d); end
    send(7, 1'b0, lat, d);
    checks++; if (d !== 1) begin errors++; $display("FAIL round_pos: got %0d expected 1", d); end
    set_taps(-3, 0, 0);
    send(10, 1'b0, lat, d);
    checks++; if (d !== -3) begin errors++; $display("FAIL round_neg_div: got %0d expected -3", d); end
  endtask

  task automatic test_backpressure();
    int lat;
    set_taps(2, 0, 0);
    bus.out_ready = 1'b0;
    bus.in_data   = 32'(200);
    bus.in_valid  = 1'b1;
    start         = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    start        = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL stall_latency: got %0d expected %0d", lat, LAT); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.out_data !== 16'sd100) begin errors++; $display("FAIL stall_data[%0d]: got %0d expected 100", i, bus.out_data); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_reset_in_div();
    int lat, d;
    bit seen;
    set_taps(819, -1966, 1311);
    send(81900, 1'b1, lat, d);
    checks++; if (d !== 100) begin errors++; $display("FAIL prep_data: got %0d expected 100", d); end
    bus.in_data  = 32'(12345);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL div_rst_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL div_rst_data: got %0d expected 0", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL div_rst_in_ready: got %b expected 0", bus.in_ready); end
    #3;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (45) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL div_rst_ghost: got %b expected 0", seen); end
    send(81900, 1'b0, lat, d);
    checks++; if (d !== 100) begin errors++; $display("FAIL div_rst_history: got %0d expected 100", d); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL div_rst_latency: got %0d expected %0d", lat, LAT); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_recover();
    test_zero_tap();
    test_wrap();
    test_round();
    test_backpressure();
    test_reset_in_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/deconvolution.md
DECONVOLUTION -- requirements
Module: deconvolution

Interface
REQ-001 SHALL have parameter N, default 16, sample width in bits (signal and coefficient).
REQ-002 SHALL have parameter LEN1, default 3, number of filter taps (LEN1 >= 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous and active-low.
REQ-005 SHALL have port signal1, input, LEN1*N, packed signed taps, tap k at [k*N +: N]; sampled only at input acceptance.
REQ-006 SHALL have port start, input, 1, single-cycle pulse that clears history; accepted only in IDLE.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 2*N, signed convolved sample y[n]).
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, N, signed recovered sample x[n]).
REQ-009 SHALL have port div_err, output, 1, sticky flag: a sample was processed with signal1 tap 0 equal to 0.

Function
REQ-010 SHALL recover x[n] = (y[n] - sum over k=1..LEN1-1 of h[k]*x[n-k]) / h[0], with x[n-k]=0 for n-k<0 or before the most recent start.
REQ-011 SHALL use FSM states IDLE, MAC, DIV, OUT; IDLE->MAC on in_valid&&in_ready; MAC->DIV after LEN1-1 cycles; DIV->OUT after 2N+2 cycles; OUT->IDLE on out_valid&&out_ready.
REQ-012 SHALL assert in_ready only in IDLE; out_valid only in OUT.
REQ-013 SHALL accumulate one tap product per MAC cycle into a signed 2N+2-bit residual; no intermediate overflow is possible.
REQ-014 SHALL divide the residual by h[0] with a restoring serial divider, one quotient bit per DIV cycle, rounding toward zero.
REQ-015 SHALL assert out_valid exactly LEN1+2N+1 rising edges after the accepting edge (36 edges for N=16, LEN1=3).
REQ-016 SHALL hold out_data stable and out_valid high while out_ready is low.
REQ-017 SHALL shift the final out_data value into the LEN1-1 entry history at the OUT->IDLE handshake.
REQ-018 SHALL, when h[0]==0, skip division: out_data = max positive if residual > 0, max negative if residual < 0, and 0 if residual == 0; set div_err; keep the same latency.
REQ-019 SHALL clear the history and div_err on start in IDLE; if start and in_valid coincide, start applies first and the sample is accepted against cleared history.

Reset
REQ-020 SHALL, with rst_n low, force state IDLE, history 0, accumulator 0, out_valid 0, out_data 0, div_err 0 and in_ready 0.
REQ-021 SHALL abandon an in-flight sample on reset in any state and never emit it.
REQ-022 SHALL assert in_ready on the first rising edge after rst_n deasserts.

Configuration
REQ-023 SHALL provide macro DECONV_SAT_EN: when defined, quotients outside the N-bit signed range saturate to 2^(N-1)-1 or -2^(N-1).
REQ-024 SHALL, without DECONV_SAT_EN, truncate the quotient to its low N bits (two's-complement wrap); REQ-018 behaviour is unchanged.

Structure
REQ-025 SHALL place the FSM state enumeration, the residual width constant (2N+2) and the saturation limits in package deconvolution_pkg.
REQ-026 SHALL implement the serial divider as sub-module deconv_div with start/done handshake, signed dividend 2N+2, divisor N, quotient 2N+2.

Verification
REQ-027 SHALL check: signal1={819,-1966,1311}, start, y={81900,-237550,235133} -> out_data {100,-50,7}, div_err=0.
REQ-028 SHALL check: tap0=0, y=5 -> out_data=32767, div_err=1; y=0 -> out_data=0; after start -> div_err=0.
REQ-029 SHALL check: signal1={1,0,0}, y=40000 -> 32767 with DECONV_SAT_EN, -25536 without.
REQ-030 SHALL check: out_ready low 10 cycles in OUT -> out_valid and out_data stable, in_ready=0, then IDLE one edge after the handshake.
REQ-031 SHALL check: rst_n pulsed low in DIV -> outputs reset at once, no output for that sample, next sample decoded with zero history.
REQ-032 SHALL check: latency from accepting edge to out_valid = 36 edges for defaults, measured on every sample of REQ-027.
